mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
//
// PURPOSE
//  Shares the single-port, byte-masked unified memory between instruction fetch (I) and load/store (D).
//  Grants one requester per cycle, with data priority and a fetch starvation guard.
//  Converts D byte/half/word accesses into a word address, replicated write data and write mask.
//  Aligns and extends the read data returned by the memory's one-cycle registered read.
//  Flags misaligned D accesses instead of forwarding them. Sits between the core and mem.
//
// PARAMETERS
//  MAX_D_STREAK  4   consecutive D grants allowed while i_req pending before I is forced (>=1)
//
// PORTS
//  clk         in   1   clock, all state on rising edge
//  reset       in   1   asynchronous, active-high reset
//  i_req       in   1   fetch request, held until i_gnt
//  i_addr      in   32  fetch byte address; bits [1:0] ignored (forced 0 toward memory)
//  i_gnt       out  1   fetch accepted this cycle (combinational)
//  i_rvalid    out  1   fetch response valid (cycle after i_gnt)
//  i_rdata     out  32  fetched word
//  d_req       in   1   load/store request, held stable until d_gnt
//  d_we        in   1   1 = store, 0 = load
//  d_addr      in   32  byte address
//  d_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  d_unsigned  in   1   loads: 1 = zero-extend, 0 = sign-extend
//  d_wdata     in   32  store data, right-justified
//  d_gnt       out  1   load/store accepted this cycle (combinational)
//  d_rvalid    out  1   load/store completion (cycle after d_gnt), for loads and stores
//  d_rdata     out  32  extended load data; 0 for stores and errors
//  d_err       out  1   misaligned/illegal access, valid with d_rvalid
//  m_we        out  1   memory write enable
//  m_a         out  32  memory byte address
//  m_wd        out  32  memory write data, lane-replicated
//  m_wm        out  4   memory byte-lane write mask
//  m_rd        in   32  memory read data, registered in memory (valid the cycle after address)
//
// BEHAVIOUR
//  - Reset: i_rvalid=0, d_rvalid=0, d_err=0, streak=0, response owner cleared.
//    While reset is high: gnt, m_we and m_wm are 0. Reset mid-access drops any pending response.
//  - Arbitration is combinational on each cycle:
//    - Only one of i_req / d_req high -> grant it.
//    - Both high -> grant D, unless streak==MAX_D_STREAK, then grant I.
//  - streak register:
//    - +1 on each D grant while i_req high.
//    - Cleared on any I grant, or on any cycle with i_req low.
//    - Saturates at MAX_D_STREAK.
//  - No grant: m_we=0, m_wm=0000, m_a=0, m_wd=0.
//  - I grant: m_a={i_addr[31:2],2'b00}, m_we=0.
//  - D grant: m_a=d_addr.
//  - Misalignment:
//    - half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//    - Still granted, but m_we=0 and m_wm=0000. Memory is never written.
//    - d_rvalid=1, d_err=1, d_rdata=0 next cycle.
//  - Store lanes (m_we=1):
//    - byte: m_wd={4{wdata[7:0]}}, m_wm=0001<<addr[1:0].
//    - half: m_wd={2{wdata[15:0]}}, m_wm = addr[1] ? 1100 : 0011.
//    - word: m_wd=wdata, m_wm=1111.
//  - Response register, captured at each grant: owner (I/D), we, addr[1:0], size, unsigned, err.
//    - The next cycle, exactly one of i_rvalid/d_rvalid pulses, per owner.
//    - Latency is fixed at 1; back-to-back grants give back-to-back responses.
//  - Load extraction uses the registered offset on m_rd:
//    - byte: lane m_rd[8*off+:8].
//    - half: m_rd[16*off[1]+:16].
//    - word: m_rd.
//    - Sign-extend unless unsigned.
//  - i_rdata=m_rd when i_rvalid, else 0. d_rdata=0 when not d_rvalid, on a store, or on err.
//  - A requester must not change request fields before its gnt. A new request may start in the response cycle.
//
// TESTING
//  1. i_req only, i_addr=0x10, RAM[4]=0x00500093 -> i_gnt same cycle; next cycle i_rvalid=1, i_rdata=0x00500093.
//  2. sb d_addr=0x23, wdata=0x000000AB -> m_wm=1000, m_wd=0xABABABAB.
//     Then lb 0x23 -> d_rdata=0xFFFFFFAB; lbu 0x23 -> 0x000000AB.
//  3. sh 0x22, wdata=0x1234 -> m_wm=1100; lh 0x22 -> 0x00001234. lw 0x20 shows bytes [15:0] unchanged.
//  4. i_req and d_req held high 10 cycles, MAX_D_STREAK=4 -> grants D,D,D,D,I,D,D,D,D,I.
//     Exactly one rvalid per cycle from cycle 2 on.
//  5. sh 0x21, lw 0x22, size=11 -> each: d_gnt, no m_we; next cycle d_err=1, d_rdata=0. Memory unchanged.
//  6. Reset asserted the cycle after a lw grant -> d_rvalid=0 immediately.
//     No response after reset release; the first grant afterwards behaves as in scenario 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between instruction fetch and load/store.
// It lane-replicates store data, builds the byte mask, and aligns/extends the registered read data.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_we,
  output logic [31:0] m_a,
  output logic [31:0] m_wd,
  output logic [3:0]  m_wm,
  input  logic [31:0] m_rd
);

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  logic [SW-1:0] streak;
  logic          force_i;
  logic          misaligned;
  logic [1:0]    unused_bits;

  owner_t        owner;
  logic          r_we;
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_uns;
  logic          r_err;

  logic [31:0]   byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_ext;

  assign unused_bits = i_addr[1:0];
  assign force_i     = (streak == SW'(MAX_D_STREAK));

  always_comb begin
    case (d_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = d_addr[0];
      2'b10:   misaligned = |d_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Data wins ties except when the fetch starvation guard has tripped.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (d_req && !(i_req && force_i)) d_gnt = 1'b1;
      else if (i_req)                   i_gnt = 1'b1;
    end
  end

  always_comb begin
    m_we = 1'b0;
    m_a  = '0;
    m_wd = '0;
    m_wm = '0;
    if (i_gnt) begin
      m_a = {i_addr[31:2], 2'b00};
    end else if (d_gnt) begin
      m_a = d_addr;
      if (d_we && !misaligned) begin
        m_we = 1'b1;
        case (d_size)
          2'b00: begin
            m_wd = {4{d_wdata[7:0]}};
            m_wm = 4'b0001 << d_addr[1:0];
          end
          2'b01: begin
            m_wd = {2{d_wdata[15:0]}};
            m_wm = d_addr[1] ? 4'b1100 : 4'b0011;
          end
          default: begin
            m_wd = d_wdata;
            m_wm = 4'b1111;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   streak <= '0;
    else if (!i_req || i_gnt)    streak <= '0;
    else if (d_gnt && !force_i)  streak <= streak + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= OWN_NONE;
      r_we   <= 1'b0;
      r_off  <= '0;
      r_size <= '0;
      r_uns  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      owner <= i_gnt ? OWN_I : (d_gnt ? OWN_D : OWN_NONE);
      if (d_gnt) begin
        r_we   <= d_we;
        r_off  <= d_addr[1:0];
        r_size <= d_size;
        r_uns  <= d_unsigned;
        r_err  <= misaligned;
      end
    end
  end

  assign byte_lane = m_rd >> {r_off, 3'b000};
  assign half_lane = m_rd[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'b00:   load_ext = {{24{~r_uns & byte_lane[7]}}, byte_lane[7:0]};
      2'b01:   load_ext = {{16{~r_uns & half_lane[15]}}, half_lane};
      default: load_ext = m_rd;
    endcase
  end

  assign i_rvalid = (owner == OWN_I);
  assign d_rvalid = (owner == OWN_D);
  assign d_err    = d_rvalid && r_err;
  assign i_rdata  = i_rvalid ? m_rd : '0;
  assign d_rdata  = (d_rvalid && !r_we && !r_err) ? load_ext : '0;

endmodule
